// File: rtl/fifo_da.sv
// fifo_da: synchronous single-clock show-ahead FIFO with arbitrary DEPTH.
//   clk         rising-edge clock for all state
//   clear       synchronous active-high reset (pointers and count only)
//   i_data_in   write data, pushed when i_write_en and not full
//   i_full_out  high when DEPTH words are stored
//   o_data_out  oldest stored word, zero when empty
//   o_read_en   pops the head when not empty
//   o_empty_out high when nothing is stored
module fifo_da #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_write_en,
  output logic             i_full_out,
  output logic [WIDTH-1:0] o_data_out,
  input  logic             o_read_en,
  output logic             o_empty_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic wr, rd;
  // gating uses the registered flags, so a write at full is dropped even when a read frees a slot
  assign wr = i_write_en & ~i_full_out;
  assign rd = o_read_en & ~o_empty_out;
  assign i_full_out = count == CW'(DEPTH);
  assign o_empty_out = count == '0;
  assign o_data_out = o_empty_out ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      if (wr & ~rd) count <= count + 1'b1;
      else if (rd & ~wr) count <= count - 1'b1;
    end
  end
  // storage has no reset; contents behind the pointers are simply stale
  always_ff @(posedge clk)
    if (wr & ~clear) mem[wr_ptr] <= i_data_in;
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!clear && i_write_en && i_full_out) $display("fifo_da: write while full dropped");
    if (!clear && o_read_en && o_empty_out) $display("fifo_da: read while empty ignored");
  end
`endif
endmodule

// File: tb/tb_fifo_da.sv
// tb_fifo_da: directed and random checks of fifo_da against a queue model.
module tb_fifo_da;
  logic clk = 0, clear = 0;
  logic [1:0] d34 = 0, o34;
  logic we34 = 0, re34 = 0, f34, e34;
  logic [7:0] d4 = 0, o4;
  logic we4 = 0, re4 = 0, f4, e4;
  logic [1:0] q34[$];
  logic [7:0] q4[$];
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  fifo_da #(.WIDTH(2), .DEPTH(34)) u34 (.clk(clk), .clear(clear), .i_data_in(d34), .i_write_en(we34),
    .i_full_out(f34), .o_data_out(o34), .o_read_en(re34), .o_empty_out(e34));
  fifo_da #(.WIDTH(8), .DEPTH(4)) u4 (.clk(clk), .clear(clear), .i_data_in(d4), .i_write_en(we4),
    .i_full_out(f4), .o_data_out(o4), .o_read_en(re4), .o_empty_out(e4));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // model: applied to the queue contents as they were before the edge
  task automatic cycle();
    bit r34, w34, r4, w4;
    r34 = re34 && q34.size() > 0;
    w34 = we34 && q34.size() < 34;
    r4 = re4 && q4.size() > 0;
    w4 = we4 && q4.size() < 4;
    @(posedge clk);
    if (clear) begin
      q34.delete();
      q4.delete();
    end else begin
      if (r34) void'(q34.pop_front());
      if (w34) q34.push_back(d34);
      if (r4) void'(q4.pop_front());
      if (w4) q4.push_back(d4);
    end
    #1;
    chk("empty34", e34, q34.size() == 0);
    chk("full34", f34, q34.size() == 34);
    chk("data34", o34, q34.size() ? q34[0] : 2'd0);
    chk("empty4", e4, q4.size() == 0);
    chk("full4", f4, q4.size() == 4);
    chk("data4", o4, q4.size() ? q4[0] : 8'd0);
    clear = 0; we34 = 0; re34 = 0; we4 = 0; re4 = 0;
  endtask
  task automatic op34(logic w, logic [1:0] d, logic r);
    we34 = w; d34 = d; re34 = r;
    cycle();
  endtask
  task automatic op4(logic w, logic [7:0] d, logic r);
    we4 = w; d4 = d; re4 = r;
    cycle();
  endtask
  initial begin
    clear = 1; we34 = 1; d34 = 2; we4 = 1; d4 = 8'h55;
    cycle();
    chk("reset_size", q34.size(), 0);
    op34(0, 0, 0);
    op34(1, 3, 0);
    op34(0, 0, 0);
    op34(0, 0, 1);
    for (int i = 0; i < 34; i++) op34(1, 2'(i % 4), 0);
    chk("full_after34", f34, 1);
    op34(1, 3, 0);
    op34(1, 2, 1);
    chk("full_rw_not_full", f34, 0);
    for (int i = 0; i < 33; i++) op34(0, 0, 1);
    chk("drained", e34, 1);
    op34(1, 1, 1);
    chk("empty_rw_data", o34, 1);
    op34(0, 0, 1);
    for (int i = 0; i < 5; i++) op34(1, 2'(i), 0);
    for (int i = 0; i < 20; i++) op34(1, 2'($urandom), 1);
    chk("count5_len", q34.size(), 5);
    for (int i = 0; i < 5; i++) op34(0, 0, 1);
    for (int i = 0; i < 3; i++) op34(0, 0, 1);
    op34(1, 1, 0);
    chk("underflow_data", o34, 1);
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) op4(1, 8'(r * 3 + k), 0);
      for (int k = 0; k < 3; k++) op4(0, 0, 1);
    end
    op4(1, 8'hA5, 0);
    op34(1, 2, 0);
    clear = 1; we34 = 1; re34 = 1; we4 = 1;
    cycle();
    for (int i = 0; i < 400; i++) begin
      we34 = 1'($urandom); re34 = ($urandom % 3) == 0; d34 = 2'($urandom);
      we4 = 1'($urandom); re4 = 1'($urandom); d4 = 8'($urandom);
      clear = ($urandom % 60) == 0;
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
